// File: rtl/req_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// req_arbiter4_pkg : shared state encodings, mode constants and helpers
// Revision: 1.0
// ============================================================================
package req_arbiter4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_arbiter4_if.sv
`default_nettype none
// ============================================================================
// req_arbiter4_if : request/grant bundle between requesters and the arbiter
// Revision: 1.0
// ============================================================================
interface req_arbiter4_if;

    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface
`default_nettype wire

// File: rtl/req_pri_enc4.sv
`default_nettype none
// ============================================================================
// req_pri_enc4 : 4-bit priority encoder, highest set bit wins
// Revision: 1.0
// ============================================================================
module req_pri_enc4
    import req_arbiter4_pkg::*;
(
    input  logic [3:0] req_i,
    output logic [1:0] idx_o,
    output logic       any_o
);

    always_comb begin
        idx_o = 2'd0;
        if (req_i[3]) begin
            idx_o = 2'd3;
        end else if (req_i[2]) begin
            idx_o = 2'd2;
        end else if (req_i[1]) begin
            idx_o = 2'd1;
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/req_arbiter4.sv
`default_nettype none
// ============================================================================
// req_arbiter4 : 4-way fixed-priority / round-robin arbiter with hold timeout
// Revision: 1.0
// ============================================================================
module req_arbiter4
    import req_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    req_arbiter4_if.slave arb_if
);

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;

    logic       w_rr_sel;
    logic [3:0] w_mask;
    logic [3:0] w_req_m;
    logic [3:0] w_rr_vec;
    logic [3:0] w_enc_in;
    logic [1:0] w_enc_idx;
    logic       w_enc_any;
    logic [1:0] w_win_idx;

    assign w_rr_sel = (arb_if.mode == MODE_RR);

    // A requester that just timed out sits out the arbitration in RELEASE only.
    assign w_mask  = (state_q == ST_RELEASE && timeout_q) ? idx_to_onehot(idx_q) : 4'b0000;
    assign w_req_m = arb_if.req & ~w_mask;

    // Pointer position lands on bit 3 so the highest-wins encoder scans upward from it.
    assign w_rr_vec = {w_req_m[ptr_q],
                       w_req_m[ptr_q + 2'd1],
                       w_req_m[ptr_q + 2'd2],
                       w_req_m[ptr_q + 2'd3]};

    assign w_enc_in = w_rr_sel ? w_rr_vec : w_req_m;

    req_pri_enc4 u_pri_enc (
        .req_i (w_enc_in),
        .idx_o (w_enc_idx),
        .any_o (w_enc_any)
    );

    assign w_win_idx = w_rr_sel ? (ptr_q + ~w_enc_idx) : w_enc_idx;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (w_enc_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = idx_to_onehot(w_win_idx);
                    idx_d   = w_win_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!arb_if.req[idx_q] || cnt_q == c_HOLD_LAST) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = 4'b0000;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 2'd1;
                    timeout_d = arb_if.req[idx_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign arb_if.gnt       = gnt_q;
    assign arb_if.gnt_idx   = idx_q;
    assign arb_if.gnt_valid = valid_q;
    assign arb_if.timeout   = timeout_q;

endmodule
`default_nettype wire
